io_xfer_ctrl: RTL and testbench

Interrupt-driven I/O transfer controller between the 1024x32 I/O memory and the 4096x32 data memory. On an I/O interrupt request it acknowledges the request and arbitrates for the memory bus against the CPU. It then copies a fixed-length block of words from the I/O memory into the data memory, one read and one write per word, and pulses Done at the end. It sits beside the CPU on the shared bus and drives the active-low chip-select and strobe lines of both memories.

---
 rtl/io_xfer_ctrl_if.sv | 37 +++
 rtl/io_xfer_ctrl.sv | 118 +++++++++++
 tb/tb_io_xfer_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : io_xfer_ctrl_if
// Purpose  : Shared-bus bundle between the I/O transfer controller, the I/O
//            memory, the data memory and the CPU bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface io_xfer_ctrl_if;
  logic        int_req;
  logic        int_ack;
  logic        bus_req;
  logic        bus_gnt;
  logic        io_cs_n;
  logic        io_rd_n;
  logic        io_wr_n;
  logic [9:0]  io_addr;
  logic [31:0] io_data;
  logic        dm_cs_n;
  logic        dm_wr_n;
  logic [11:0] dm_addr;
  logic [31:0] dm_data;
  logic        dm_data_oe;
  logic        done;

  modport master (
    input  int_req, bus_gnt, io_data,
    output int_ack, bus_req, io_cs_n, io_rd_n, io_wr_n, io_addr,
           dm_cs_n, dm_wr_n, dm_addr, dm_data, dm_data_oe, done
  );

  modport slave (
    output int_req, bus_gnt, io_data,
    input  int_ack, bus_req, io_cs_n, io_rd_n, io_wr_n, io_addr,
           dm_cs_n, dm_wr_n, dm_addr, dm_data, dm_data_oe, done
  );
endinterface
`default_nettype wire

// File: rtl/io_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_xfer_ctrl
// Purpose  : Interrupt-driven block copy from I/O memory to data memory over
//            the shared bus; XFER_STATS_EN adds transfer/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module io_xfer_ctrl #(
  parameter int unsigned XFER_LEN = 16,
  parameter logic [9:0]  IO_BASE  = 10'h000,
  parameter logic [11:0] DM_BASE  = 12'h100
) (
  input  logic           clk,
  input  logic           rst_n,
  io_xfer_ctrl_if.master bus
`ifdef XFER_STATS_EN
  ,
  output logic [15:0]    xfer_cnt,
  output logic [15:0]    stall_cnt
`endif
);

  localparam logic [9:0] C_LAST_IDX = 10'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACK  = 3'd1,
    S_BREQ = 3'd2,
    S_RD   = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  logic [9:0]  r_idx;
  logic [9:0]  r_io_addr;
  logic [11:0] r_dm_addr;
  logic [31:0] r_buf;
  logic        w_rd_act;
  logic        w_wr_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_io_addr <= IO_BASE;
      r_dm_addr <= DM_BASE;
      r_buf     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.int_req) r_state <= S_ACK;
        S_ACK:  if (!bus.int_req) r_state <= S_BREQ;
        S_BREQ: begin
          if (bus.bus_gnt) begin
            r_state   <= S_RD;
            r_idx     <= '0;
            r_io_addr <= IO_BASE;
            r_dm_addr <= DM_BASE;
          end
        end
        S_RD: begin
          if (bus.bus_gnt) begin
            r_buf   <= bus.io_data;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          if (bus.bus_gnt) begin
            if (r_idx == C_LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              // Address registers wrap naturally at their widths.
              r_idx     <= r_idx + 10'd1;
              r_io_addr <= r_io_addr + 10'd1;
              r_dm_addr <= r_dm_addr + 12'd1;
              r_state   <= S_RD;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are withheld whenever the arbiter has taken the bus back.
  assign w_rd_act = (r_state == S_RD) && bus.bus_gnt;
  assign w_wr_act = (r_state == S_WR) && bus.bus_gnt;

  assign bus.int_ack    = (r_state == S_ACK);
  assign bus.bus_req    = (r_state == S_BREQ) || (r_state == S_RD) || (r_state == S_WR);
  assign bus.done       = (r_state == S_DONE);
  assign bus.io_cs_n    = ~w_rd_act;
  assign bus.io_rd_n    = ~w_rd_act;
  assign bus.io_wr_n    = 1'b1;
  assign bus.io_addr    = r_io_addr;
  assign bus.dm_cs_n    = ~w_wr_act;
  assign bus.dm_wr_n    = ~w_wr_act;
  assign bus.dm_data_oe = w_wr_act;
  assign bus.dm_addr    = r_dm_addr;
  assign bus.dm_data    = r_buf;

`ifdef XFER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if ((r_state == S_DONE) && (xfer_cnt != 16'hFFFF))
        xfer_cnt <= xfer_cnt + 16'd1;
      if (((r_state == S_RD) || (r_state == S_WR)) && !bus.bus_gnt && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_xfer_ctrl
// Purpose  : Self-checking bench for io_xfer_ctrl (main and address-wrap instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_xfer_ctrl;

  localparam int          LEN  = 4;
  localparam logic [9:0]  IOB  = 10'h000;
  localparam logic [11:0] DMB  = 12'h100;
  localparam int          WLEN = 3;
  localparam logic [9:0]  WIOB = 10'd1022;
  localparam logic [11:0] WDMB = 12'd4095;
  localparam logic [62:0] RST_VEC = {4'b0000, 5'b11111, IOB, DMB, 32'h0};

  typedef struct { bit in_rst; logic req; logic gnt; logic [62:0] exp; } rvec_t;
  typedef struct { int gdelay; int st_at; int st_len; int exp_lat; } xvec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_viol   = 0;
  int w_viol   = 0;

  logic [9:0]  m_rd_q[$];
  logic [11:0] m_wa_q[$];
  logic [31:0] m_wd_q[$];
  logic [9:0]  w_rd_q[$];
  logic [11:0] w_wa_q[$];
  logic [31:0] w_wd_q[$];
  logic [31:0] io_mem [1024];

  io_xfer_ctrl_if m_if();
  io_xfer_ctrl_if w_if();

  assign m_if.io_data = io_mem[m_if.io_addr];
  assign w_if.io_data = io_mem[w_if.io_addr];

`ifdef XFER_STATS_EN
  logic [15:0] m_xfer_cnt, m_stall_cnt, w_xfer_cnt, w_stall_cnt;
`endif

  io_xfer_ctrl #(.XFER_LEN(LEN), .IO_BASE(IOB), .DM_BASE(DMB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
`ifdef XFER_STATS_EN
    , .xfer_cnt (m_xfer_cnt), .stall_cnt (m_stall_cnt)
`endif
  );

  io_xfer_ctrl #(.XFER_LEN(WLEN), .IO_BASE(WIOB), .DM_BASE(WDMB)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_if)
`ifdef XFER_STATS_EN
    , .xfer_cnt (w_xfer_cnt), .stall_cnt (w_stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [62:0] outs_m();
    return {m_if.int_ack, m_if.bus_req, m_if.done, m_if.dm_data_oe,
            m_if.io_cs_n, m_if.io_rd_n, m_if.io_wr_n, m_if.dm_cs_n, m_if.dm_wr_n,
            m_if.io_addr, m_if.dm_addr, m_if.dm_data};
  endfunction

  // One bus cycle: drive at the falling edge, observe shortly after, and act as both memories.
  task automatic cycle(input logic req, input logic gnt);
    @(negedge clk);
    m_if.int_req = req;
    m_if.bus_gnt = gnt;
    #1;
    if (!m_if.io_cs_n && !m_if.io_rd_n) m_rd_q.push_back(m_if.io_addr);
    if (!m_if.dm_cs_n && !m_if.dm_wr_n && m_if.dm_data_oe) begin
      m_wa_q.push_back(m_if.dm_addr);
      m_wd_q.push_back(m_if.dm_data);
    end
    if (!m_if.io_rd_n && !m_if.dm_wr_n) m_viol++;
    if (!m_if.bus_gnt && (!m_if.io_rd_n || !m_if.dm_wr_n || m_if.dm_data_oe)) m_viol++;
    if (m_if.io_wr_n !== 1'b1) m_viol++;
    if (!w_if.io_cs_n && !w_if.io_rd_n) w_rd_q.push_back(w_if.io_addr);
    if (!w_if.dm_cs_n && !w_if.dm_wr_n && w_if.dm_data_oe) begin
      w_wa_q.push_back(w_if.dm_addr);
      w_wd_q.push_back(w_if.dm_data);
    end
    if (!w_if.io_rd_n && !w_if.dm_wr_n) w_viol++;
    if (!w_if.bus_gnt && (!w_if.io_rd_n || !w_if.dm_wr_n || w_if.dm_data_oe)) w_viol++;
    if (w_if.io_wr_n !== 1'b1) w_viol++;
  endtask

  // Word i of a block: read IO_BASE+i, write DM_BASE+i, both modulo memory size.
  task automatic check_words(input int nr, input int nw);
    logic [9:0]  ia;
    logic [11:0] ea;
    chk("io read count", m_rd_q.size(), nr);
    chk("dm write count", m_wa_q.size(), nw);
    for (int i = 0; i < nr && i < m_rd_q.size(); i++) begin
      ia = 10'((int'(IOB) + i) % 1024);
      chk("io read addr", m_rd_q[i], ia);
    end
    for (int i = 0; i < nw && i < m_wa_q.size(); i++) begin
      ia = 10'((int'(IOB) + i) % 1024);
      ea = 12'((int'(DMB) + i) % 4096);
      chk("dm write addr/data", {m_wa_q[i], m_wd_q[i]}, {ea, io_mem[ia]});
    end
  endtask

  task automatic xfer(input int gdelay, input int st_at, input int st_len, input int req_at,
                      input int abort_at, input bit rnd, output int lat, output int stalls);
    bit got;
    bit req;
    bit gnt;
    bit aborted;
    int early;
`ifdef XFER_STATS_EN
    logic [15:0] s0;
    logic [15:0] x0;
    s0 = m_stall_cnt;
    x0 = m_xfer_cnt;
`endif
    got = 1'b0; req = 1'b0; gnt = 1'b0; aborted = 1'b0; early = 0;
    lat = -1; stalls = 0;
    m_rd_q.delete(); m_wa_q.delete(); m_wd_q.delete();
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1'b1, 1'b0);
      got = m_if.int_ack;
    end
    chk("int_ack raised", got, 1);
    cycle(1'b0, 1'b0);
    for (int i = 0; i <= gdelay; i++) begin
      cycle(1'b0, i == gdelay);
      if (i == 0) chk("breq outputs", {m_if.int_ack, m_if.bus_req, m_if.io_cs_n, m_if.dm_cs_n}, 4'b0111);
    end
    for (int c = 1; c < 2 * LEN + 300; c++) begin
      if (req_at != 0 && c >= req_at) req = 1'b1;
      if (rnd) gnt = ($urandom_range(0, 3) != 0);
      else     gnt = !(st_at != 0 && c >= st_at && c < st_at + st_len);
      cycle(req, gnt);
      if (m_if.int_ack) early++;
      if (m_if.done) begin
        lat = c - 1;
        break;
      end
      if (!gnt) stalls++;
      if (c == abort_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset strobes", {m_if.io_cs_n, m_if.io_rd_n}, 2'b11);
        chk("async reset outputs", outs_m(), RST_VEC);
        check_words((abort_at + 1) / 2, abort_at / 2);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      chk("done seen", lat >= 0, 1);
      chk("no int_ack mid-transfer", early, 0);
      chk("bus_req low in DONE", m_if.bus_req, 0);
      cycle(req, 1'b1);
      chk("done single pulse", m_if.done, 0);
      check_words(LEN, LEN);
`ifdef XFER_STATS_EN
      chk("stall_cnt delta", 16'(m_stall_cnt - s0), stalls);
      chk("xfer_cnt delta", 16'(m_xfer_cnt - x0), 1);
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rvec_t rtbl[8];
    xvec_t xtbl[3];
    bit    got;
    int    lat;
    int    stalls;
    logic [9:0]  ia;
    logic [11:0] ea;

    for (int i = 0; i < 8; i++) begin
      rtbl[i].in_rst = (i < 4);
      rtbl[i].req    = (i < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      rtbl[i].gnt    = 1'($urandom_range(0, 1));
      rtbl[i].exp    = RST_VEC;
    end
    xtbl[0] = '{0, 0, 0, 8};
    xtbl[1] = '{5, 6, 3, 11};
    xtbl[2] = '{2, 1, 2, 10};

    m_if.int_req = 1'b0; m_if.bus_gnt = 1'b0;
    w_if.int_req = 1'b0; w_if.bus_gnt = 1'b0;
    for (int i = 0; i < 1024; i++) io_mem[i] = $urandom;

    for (int i = 0; i < 8; i++) begin
      rst_n = !rtbl[i].in_rst;
      cycle(rtbl[i].req, rtbl[i].gnt);
      chk(rtbl[i].in_rst ? "outputs in reset" : "idle after release", outs_m(), rtbl[i].exp);
    end
`ifdef XFER_STATS_EN
    chk("xfer_cnt after reset", m_xfer_cnt, 0);
    chk("stall_cnt after reset", m_stall_cnt, 0);
`endif

    for (int i = 0; i < 3; i++) begin
      xfer(xtbl[i].gdelay, xtbl[i].st_at, xtbl[i].st_len, 0, 0, 1'b0, lat, stalls);
      chk("table done latency", lat, xtbl[i].exp_lat);
    end

    // Int_req raised during word 1 must wait for Done, then start a full second block.
    xfer(0, 0, 0, 3, 0, 1'b0, lat, stalls);
    chk("b2b first latency", lat, 2 * LEN);
    xfer(0, 0, 0, 0, 0, 1'b0, lat, stalls);
    chk("b2b second latency", lat, 2 * LEN);

    xfer(0, 0, 0, 0, 5, 1'b0, lat, stalls);
    xfer(0, 0, 0, 0, 0, 1'b0, lat, stalls);
    chk("restart latency", lat, 2 * LEN);

    w_rd_q.delete(); w_wa_q.delete(); w_wd_q.delete();
    got = 1'b0;
    w_if.int_req = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(1'b0, 1'b0);
      got = w_if.int_ack;
    end
    chk("wrap int_ack", got, 1);
    w_if.int_req = 1'b0;
    w_if.bus_gnt = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(1'b0, 1'b0);
      got = w_if.done;
    end
    chk("wrap done seen", got, 1);
    chk("wrap bus_req in DONE", w_if.bus_req, 0);
    w_if.bus_gnt = 1'b0;
    chk("wrap read count", w_rd_q.size(), WLEN);
    chk("wrap write count", w_wa_q.size(), WLEN);
    for (int i = 0; i < WLEN && i < w_rd_q.size(); i++) begin
      ia = 10'((int'(WIOB) + i) % 1024);
      chk("wrap read addr", w_rd_q[i], ia);
    end
    for (int i = 0; i < WLEN && i < w_wa_q.size(); i++) begin
      ia = 10'((int'(WIOB) + i) % 1024);
      ea = 12'((int'(WDMB) + i) % 4096);
      chk("wrap write addr/data", {w_wa_q[i], w_wd_q[i]}, {ea, io_mem[ia]});
    end
`ifdef XFER_STATS_EN
    chk("wrap xfer_cnt", w_xfer_cnt, 1);
    chk("wrap stall_cnt", w_stall_cnt, 0);
`endif

    for (int k = 0; k < 15; k++) begin
      for (int i = 0; i < 1024; i++) io_mem[i] = $urandom;
      xfer($urandom_range(0, 6), 0, 0, 0, 0, 1'b1, lat, stalls);
      chk("random latency", lat, 2 * LEN + stalls);
    end

    chk("main strobe rules", m_viol, 0);
    chk("wrap strobe rules", w_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
